// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding, limits, helpers.
package serial_adder_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned WIDTH_MAX = 64;

    // FSM state encoding; 2'd3 is unused and recovers to IDLE
    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] RUN  = 2'd1;
    localparam logic [STATE_W-1:0] DONE = 2'd2;

    // Bit-counter width: enough to count WIDTH bit-cycles, never narrower than 1
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between an operand producer and the serial adder.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout_out;

    // Producer side: issues requests, observes status and results
    modport master (
        output start,
        output a_in,
        output b_in,
        output cin_in,
        input  busy,
        input  done,
        input  sum_out,
        input  cout_out
    );

    // Adder side: accepts requests, returns status and results
    modport slave (
        input  start,
        input  a_in,
        input  b_in,
        input  cin_in,
        output busy,
        output done,
        output sum_out,
        output cout_out
    );

endinterface

// File: rtl/serial_adder_fa.sv
// One-bit full-adder cell shared across the codebase.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and majority carry
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: a_in + b_in + cin_in over WIDTH cycles, LSB first,
// through a single full-adder cell. Legal WIDTH range is 1..WIDTH_MAX.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);

    localparam int unsigned      CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [STATE_W-1:0] state_q,    state_d;
    logic [WIDTH-1:0]   a_sh_q,     a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,     b_sh_d;
    logic [WIDTH-1:0]   sum_sh_q,   sum_sh_d;
    logic               carry_q,    carry_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic [WIDTH-1:0]   sum_out_q,  sum_out_d;
    logic               cout_out_q, cout_out_d;

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   sum_nxt;

    // Single full-adder cell fed from the operand shift-register LSBs
    fa u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 is at the LSB.
    // Written as a shift of the concatenation so WIDTH=1 needs no special case.
    assign sum_nxt = WIDTH'({fa_sum, sum_sh_q} >> 1);

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        sum_sh_d   = sum_sh_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        sum_out_d  = sum_out_q;
        cout_out_d = cout_out_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    a_sh_d   = bus.a_in;
                    b_sh_d   = bus.b_in;
                    carry_d  = bus.cin_in;
                    cnt_d    = '0;
                    sum_sh_d = '0;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_nxt;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    sum_out_d  = sum_nxt;
                    cout_out_d = fa_cout;
                end else begin
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any addition in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            sum_sh_q   <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sum_out_q  <= '0;
            cout_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            sum_sh_q   <= sum_sh_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sum_out_q  <= sum_out_d;
            cout_out_q <= cout_out_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum_out  = sum_out_q;
    assign bus.cout_out = cout_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 builds).
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the 8-bit DUT idle; returns just after the accept edge
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c);
        bus8.start  = 1'b1;
        bus8.a_in   = a;
        bus8.b_in   = b;
        bus8.cin_in = c;
        @(negedge clk);
        bus8.start  = 1'b0;
    endtask

    // Counts edges after the accept edge until done, plus busy cycles seen on the way
    task automatic wait_done8(output int edges, output int busy_cnt, output logic overlap);
        edges    = 0;
        busy_cnt = 0;
        overlap  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus8.busy && bus8.done) overlap = 1'b1;
            if (bus8.done) break;
            if (bus8.busy) busy_cnt++;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] exp_sum, input logic exp_cout);
        int   edges;
        int   busy_cnt;
        logic overlap;
        launch8(a, b, c);
        wait_done8(edges, busy_cnt, overlap);
        check({tag, "_latency"}, 64'(edges), 64'd8);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd8);
        check({tag, "_busy_done_overlap"}, 64'(overlap), 64'd0);
        check({tag, "_sum"}, 64'(bus8.sum_out), 64'(exp_sum));
        check({tag, "_cout"}, 64'(bus8.cout_out), 64'(exp_cout));
        @(negedge clk);
        check({tag, "_done_single"}, 64'(bus8.done), 64'd0);
        check({tag, "_idle_busy"}, 64'(bus8.busy), 64'd0);
    endtask

    initial begin
        logic [8:0] expq[$];
        int         acc_cyc[$];
        logic       prev_busy;
        logic [7:0] cur_a;
        logic [7:0] cur_b;
        logic       cur_c;
        int         pulses;
        logic [7:0] got_sum;
        logic       got_cout;
        logic [8:0] e;

        rst_n       = 1'b0;
        bus8.start  = 1'b0;
        bus8.a_in   = '0;
        bus8.b_in   = '0;
        bus8.cin_in = 1'b0;
        bus1.start  = 1'b0;
        bus1.a_in   = '0;
        bus1.b_in   = '0;
        bus1.cin_in = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus8.busy), 64'd0);
        check("rst_done", 64'(bus8.done), 64'd0);
        check("rst_sum", 64'(bus8.sum_out), 64'd0);
        check("rst_cout", 64'(bus8.cout_out), 64'd0);
        check("rst_w1_sum", 64'(bus1.sum_out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic additions, including full carry propagation
        run8("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // start and operand changes during RUN and DONE are ignored
        launch8(8'h12, 8'h34, 1'b0);
        repeat (2) @(negedge clk);
        bus8.start  = 1'b1;
        bus8.a_in   = 8'h00;
        bus8.b_in   = 8'h00;
        bus8.cin_in = 1'b1;
        @(negedge clk);
        bus8.start  = 1'b0;
        pulses   = 0;
        got_sum  = 8'h00;
        got_cout = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus8.done) begin
                if (pulses == 0) begin
                    got_sum  = bus8.sum_out;
                    got_cout = bus8.cout_out;
                end
                pulses++;
                bus8.start = 1'b1;
            end else begin
                bus8.start = 1'b0;
            end
            @(negedge clk);
        end
        bus8.start = 1'b0;
        check("ign_pulses", 64'(pulses), 64'd1);
        check("ign_sum", 64'(got_sum), 64'h46);
        check("ign_cout", 64'(got_cout), 64'd0);
        check("ign_idle_busy", 64'(bus8.busy), 64'd0);

        // Asynchronous reset in the middle of RUN
        launch8(8'hAB, 8'hCD, 1'b1);
        repeat (3) @(negedge clk);
        check("prerst_busy", 64'(bus8.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(bus8.busy), 64'd0);
        check("midrst_done", 64'(bus8.done), 64'd0);
        check("midrst_sum", 64'(bus8.sum_out), 64'd0);
        check("midrst_cout", 64'(bus8.cout_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("postrst_busy", 64'(bus8.busy), 64'd0);
        check("postrst_done", 64'(bus8.done), 64'd0);
        run8("post_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

        // start held high with operands changing every cycle
        prev_busy = bus8.busy;
        for (int i = 0; i < 40; i++) begin
            cur_a       = 8'(8'h11 + 3 * i);
            cur_b       = 8'(8'hF0 + 7 * i);
            cur_c       = 1'(i);
            bus8.start  = 1'b1;
            bus8.a_in   = cur_a;
            bus8.b_in   = cur_b;
            bus8.cin_in = cur_c;
            @(negedge clk);
            if (bus8.busy && !prev_busy) begin
                expq.push_back(9'(cur_a) + 9'(cur_b) + 9'(cur_c));
                acc_cyc.push_back(i);
            end
            if (bus8.done) begin
                check("cont_pending", 64'(expq.size() != 0), 64'd1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    check("cont_result", 64'({bus8.cout_out, bus8.sum_out}), 64'(e));
                end
            end
            prev_busy = bus8.busy;
        end
        bus8.start = 1'b0;
        check("cont_accepts", 64'(acc_cyc.size()), 64'd4);
        check("cont_outstanding", 64'(expq.size()), 64'd0);
        if (acc_cyc.size() > 0) check("cont_first_accept", 64'(acc_cyc[0]), 64'd0);
        for (int j = 1; j < acc_cyc.size(); j++) begin
            check("cont_spacing", 64'(acc_cyc[j] - acc_cyc[j-1]), 64'd10);
        end
        repeat (12) @(negedge clk);

        // WIDTH=1 build: one RUN cycle, done on the next edge
        bus1.start  = 1'b1;
        bus1.a_in   = 1'b1;
        bus1.b_in   = 1'b1;
        bus1.cin_in = 1'b1;
        @(negedge clk);
        bus1.start  = 1'b0;
        check("w1_busy", 64'(bus1.busy), 64'd1);
        check("w1_done_early", 64'(bus1.done), 64'd0);
        @(negedge clk);
        check("w1_done", 64'(bus1.done), 64'd1);
        check("w1_busy_off", 64'(bus1.busy), 64'd0);
        check("w1_sum", 64'(bus1.sum_out), 64'd1);
        check("w1_cout", 64'(bus1.cout_out), 64'd1);
        @(negedge clk);
        check("w1_done_single", 64'(bus1.done), 64'd0);
        bus1.start  = 1'b1;
        bus1.a_in   = 1'b0;
        bus1.b_in   = 1'b0;
        bus1.cin_in = 1'b1;
        @(negedge clk);
        bus1.start  = 1'b0;
        @(negedge clk);
        check("w1b_done", 64'(bus1.done), 64'd1);
        check("w1b_sum", 64'(bus1.sum_out), 64'd1);
        check("w1b_cout", 64'(bus1.cout_out), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
